dlx_mem_arbiter: RTL and testbench

DLX_MEM_ARBITER -- requirements
Module: dlx_mem_arbiter

---
 rtl/dlx_pkg.sv | 28 ++
 rtl/dlx_arb_rdret.sv | 40 ++++
 rtl/dlx_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dlx_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX memory arbiter: arbiter state encoding,
// requester port ids, default widths and the burst counter width.
package dlx_pkg;

    localparam int DLX_ADDR_W    = 32;
    localparam int DLX_DATA_W    = 32;
    localparam int DLX_MAX_BURST = 8;

    // Burst counter saturates at its all-ones value.
    localparam int               BURST_CNT_W   = 8;
    localparam logic [BURST_CNT_W-1:0] BURST_CNT_MAX = '1;

    // Requester ids; also the index into the per-port read-return vectors.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DBG = 2'd2
    } arb_state_t;

    // Grant state that corresponds to a requester id.
    function automatic arb_state_t grant_state(input logic port);
        return (port == PORT_DBG) ? GNT_DBG : GNT_CPU;
    endfunction

endpackage

// File: rtl/dlx_arb_rdret.sv
// One-cycle read-return router. The RAM answers a read one cycle after the
// beat, so the issuing port is latched with the beat and the returning data is
// steered to that port only, independent of any grant change in between.
module dlx_arb_rdret
    import dlx_pkg::*;
#(
    parameter int DATA_W = DLX_DATA_W
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   issue_read,
    input  logic                   issue_port,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic [1:0]             rvalid,
    output logic [1:0][DATA_W-1:0] rdata
);

    logic pend_reg;
    logic port_reg;

    // Remember whether a read was issued last cycle and by whom.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pend_reg <= 1'b0;
            port_reg <= PORT_CPU;
        end else begin
            pend_reg <= issue_read;
            if (issue_read) begin
                port_reg <= issue_port;
            end
        end
    end

    // Per-port return: only the issuing port sees valid and data, others stay 0.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign rvalid[gi] = pend_reg && (port_reg == 1'(gi));
        assign rdata[gi]  = rvalid[gi] ? ram_rdata : '0;
    end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Two-requester arbiter (CPU data port, debug/loader port) in front of a
// single-port RAM with 1-cycle synchronous read. Grants are registered in the
// state register; a burst counter forces a hand-over after MAX_BURST beats
// when the other port is waiting.
// Optional feature: define ARB_ROUND_ROBIN_EN to break simultaneous IDLE
// requests in favour of the port not granted last (default: CPU priority).
module dlx_mem_arbiter
    import dlx_pkg::*;
#(
    parameter int ADDR_W    = DLX_ADDR_W,
    parameter int DATA_W    = DLX_DATA_W,
    parameter int MAX_BURST = DLX_MAX_BURST
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

    arb_state_t             state_reg, state_next;
    logic [BURST_CNT_W-1:0] count_reg, count_next;

    logic              owner_port;
    logic              owner_req;
    logic              owner_we;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wdata;
    logic              other_req;
    logic              beat;
    logic              idle_pick;

    logic [1:0]             rd_valid;
    logic [1:0][DATA_W-1:0] rd_data;

    // Select the current owner's request signals and the competitor's request.
    always_comb begin
        owner_port  = (state_reg == GNT_DBG) ? PORT_DBG : PORT_CPU;
        owner_req   = 1'b0;
        owner_we    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        other_req   = 1'b0;
        case (state_reg)
            GNT_CPU: begin
                owner_req   = cpu_req_i;
                owner_we    = cpu_we_i;
                owner_addr  = cpu_addr_i;
                owner_wdata = cpu_wdata_i;
                other_req   = dbg_req_i;
            end
            GNT_DBG: begin
                owner_req   = dbg_req_i;
                owner_we    = dbg_we_i;
                owner_addr  = dbg_addr_i;
                owner_wdata = dbg_wdata_i;
                other_req   = cpu_req_i;
            end
            default: ;
        endcase
        // owner_req is 0 in IDLE, so this is grant AND owner request.
        beat = owner_req;
    end

    assign cpu_gnt_o   = (state_reg == GNT_CPU);
    assign dbg_gnt_o   = (state_reg == GNT_DBG);
    assign ram_we_o    = beat & owner_we;
    assign ram_addr_o  = beat ? owner_addr  : '0;
    assign ram_wdata_o = beat ? owner_wdata : '0;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_reg;

    // Track which port held the grant most recently (CPU after reset).
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            last_owner_reg <= PORT_CPU;
        end else if (state_reg == GNT_CPU) begin
            last_owner_reg <= PORT_CPU;
        end else if (state_reg == GNT_DBG) begin
            last_owner_reg <= PORT_DBG;
        end
    end

    // Simultaneous IDLE requests go to the port that was not granted last.
    always_comb begin
        if (cpu_req_i && dbg_req_i) begin
            idle_pick = ~last_owner_reg;
        end else begin
            idle_pick = cpu_req_i ? PORT_CPU : PORT_DBG;
        end
    end
`else
    // Fixed priority: the CPU wins simultaneous IDLE requests.
    assign idle_pick = cpu_req_i ? PORT_CPU : PORT_DBG;
`endif

    // Arbiter state and burst counter registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next grant: hand over on owner release or on a full burst with a waiter.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    state_next = grant_state(idle_pick);
                end
            end
            GNT_CPU, GNT_DBG: begin
                if (!owner_req) begin
                    state_next = other_req ? grant_state(~owner_port) : IDLE;
                end else if (other_req && (count_reg == BURST_LAST)) begin
                    state_next = grant_state(~owner_port);
                end
            end
            default: state_next = IDLE;
        endcase
        // Any state change starts a fresh burst; otherwise count beats, saturating.
        if (state_next != state_reg) begin
            count_next = '0;
        end else if (beat && (count_reg != BURST_CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    dlx_arb_rdret #(
        .DATA_W (DATA_W)
    ) u_rdret (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .issue_read (beat & ~owner_we),
        .issue_port (owner_port),
        .ram_rdata  (ram_rdata_i),
        .rvalid     (rd_valid),
        .rdata      (rd_data)
    );

    assign cpu_rvalid_o = rd_valid[PORT_CPU];
    assign cpu_rdata_o  = rd_data[PORT_CPU];
    assign dbg_rvalid_o = rd_valid[PORT_DBG];
    assign dbg_rdata_o  = rd_data[PORT_DBG];

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Testbench for dlx_mem_arbiter: directed stimulus with a behavioural RAM.
// Read expectations go into per-port queues when a read beat is issued; a
// negedge monitor pops and compares whenever a port presents rvalid.
// Expectations follow ARB_ROUND_ROBIN_EN when the macro is defined.
module tb_dlx_mem_arbiter;
    import dlx_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;
    logic        cpu_gnt_o, cpu_rvalid_o, dbg_gnt_o, dbg_rvalid_o, ram_we_o;
    logic [31:0] cpu_rdata_o, dbg_rdata_o, ram_addr_o, ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        dbg_q[$];
    logic [31:0] mem [256];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    dlx_mem_arbiter dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_gnt_o    (cpu_gnt_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_gnt_o    (dbg_gnt_o),
        .dbg_rvalid_o (dbg_rvalid_o),
        .dbg_rdata_o  (dbg_rdata_o),
        .ram_addr_o   (ram_addr_o),
        .ram_we_o     (ram_we_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rdata_i  (ram_rdata_i)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc <= cyc + 1;

    // Behavioural RAM: synchronous 1-cycle read, read-before-write.
    always @(posedge clock_i) begin
        ram_rdata_i <= mem[ram_addr_o[7:0]];
        if (ram_we_o) mem[ram_addr_o[7:0]] <= ram_wdata_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cyc_start();
        @(posedge clock_i);
        #1;
    endtask

    task automatic cyc_sample();
        @(negedge clock_i);
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        cpu_req_i = req; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        dbg_req_i = req; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
    endtask

    // A read beat in this cycle must return on its port in the next cycle.
    task automatic exp_read(input logic port, input logic [31:0] data);
        exp_t e;
        e.data = data;
        e.due  = cyc + 1;
        if (port == PORT_DBG) dbg_q.push_back(e);
        else                  cpu_q.push_back(e);
    endtask

    // Read-return monitor.
    always @(negedge clock_i) begin
        exp_t e;
        if (cpu_rvalid_o) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", cpu_rvalid_o, 0);
            else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", cpu_rdata_o, e.data);
                chk("cpu_rvalid_cycle", cyc, e.due);
            end
        end else begin
            chk("cpu_rdata_quiet", cpu_rdata_o, 0);
            if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
                e = cpu_q.pop_front();
                chk("cpu_rvalid_missing", cpu_rvalid_o, 1);
            end
        end
        if (dbg_rvalid_o) begin
            if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", dbg_rvalid_o, 0);
            else begin
                e = dbg_q.pop_front();
                chk("dbg_rdata", dbg_rdata_o, e.data);
                chk("dbg_rvalid_cycle", cyc, e.due);
            end
        end else begin
            chk("dbg_rdata_quiet", dbg_rdata_o, 0);
            if (dbg_q.size() != 0 && dbg_q[0].due <= cyc) begin
                e = dbg_q.pop_front();
                chk("dbg_rvalid_missing", dbg_rvalid_o, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cpu_beats_pre;
        bit seen_dbg;

        reset_i = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hCAFEF00D;

        // Reset state.
        repeat (2) @(posedge clock_i);
        cyc_sample();
        chk("rst_cpu_gnt", cpu_gnt_o, 0);
        chk("rst_dbg_gnt", dbg_gnt_o, 0);
        chk("rst_ram_we", ram_we_o, 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_state", dut.state_reg, IDLE);
        cyc_start();
        reset_i = 1'b0;

        // Single CPU read of 0x10.
        cyc_start(); set_cpu(1, 0, 32'h10, 0);
        cyc_sample(); chk("t1_no_gnt_same_cycle", cpu_gnt_o, 0);
        cyc_start();
        cyc_sample();
        chk("t1_cpu_gnt", cpu_gnt_o, 1);
        chk("t1_dbg_gnt", dbg_gnt_o, 0);
        chk("t1_ram_addr", ram_addr_o, 32'h10);
        chk("t1_ram_we", ram_we_o, 0);
        exp_read(PORT_CPU, 32'hDEADBEEF);
        cyc_start(); set_cpu(0, 0, 0, 0);
        cyc_sample(); chk("t1_nonbeat_addr", ram_addr_o, 0);
        cyc_start();
        cyc_sample(); chk("t1_back_idle", dut.state_reg, IDLE);

        // Simultaneous requests in IDLE.
        cyc_start(); set_cpu(1, 0, 32'h10, 0); set_dbg(1, 0, 32'h20, 0);
        cyc_sample();
        cyc_start();
        cyc_sample();
        chk("t2_first_cpu_gnt", cpu_gnt_o, !RR_EN);
        chk("t2_first_dbg_gnt", dbg_gnt_o, RR_EN);
        exp_read(RR_EN, RR_EN ? 32'hCAFEF00D : 32'hDEADBEEF);
        cyc_start();
        if (RR_EN) set_dbg(0, 0, 0, 0);
        else       set_cpu(0, 0, 0, 0);
        cyc_sample();
        cyc_start();
        cyc_sample();
        chk("t2_second_cpu_gnt", cpu_gnt_o, RR_EN);
        chk("t2_second_dbg_gnt", dbg_gnt_o, !RR_EN);
        exp_read(!RR_EN, RR_EN ? 32'hDEADBEEF : 32'hCAFEF00D);
        cyc_start(); set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0);
        cyc_sample();
        cyc_start();
        cyc_sample(); chk("t2_back_idle", dut.state_reg, IDLE);

        // CPU stream of 20 beats (beat 7 reads 0x10) while DBG writes 0x40 then reads it.
        cpu_beats_pre = 0;
        seen_dbg = 1'b0;
        for (int c = 0; c <= 26; c++) begin
            int k;
            cyc_start();
            k = (c <= 1) ? 0 : (c <= 8) ? c - 1 : (c <= 11) ? 8 : c - 4;
            if (c <= 23) set_cpu(1, (k != 7), (k == 7) ? 32'h10 : 32'h80 + k, 32'h100 + k);
            else         set_cpu(0, 0, 0, 0);
            if (c >= 1 && c <= 9) set_dbg(1, 1, 32'h40, 32'h1234);
            else if (c == 10)     set_dbg(1, 0, 32'h40, 0);
            else                  set_dbg(0, 0, 0, 0);
            cyc_sample();
            chk("t3_cpu_gnt", cpu_gnt_o, (c >= 1 && c <= 8) || (c >= 12 && c <= 24));
            chk("t3_dbg_gnt", dbg_gnt_o, (c >= 9 && c <= 11));
            if (dbg_gnt_o) seen_dbg = 1'b1;
            if (!seen_dbg && cpu_gnt_o && cpu_req_i) cpu_beats_pre++;
            if (c == 8) exp_read(PORT_CPU, 32'hDEADBEEF);
            if (c == 9) begin
                chk("t3_dbg_wr_we", ram_we_o, 1);
                chk("t3_dbg_wr_addr", ram_addr_o, 32'h40);
                chk("t3_dbg_wr_data", ram_wdata_o, 32'h1234);
            end
            if (c == 10) exp_read(PORT_DBG, 32'h1234);
        end
        chk("t3_cpu_beats_before_switch", cpu_beats_pre, 8);
        chk("t3_cpu_wr_first", mem[8'h80], 32'h100);
        chk("t3_cpu_wr_last", mem[8'h80 + 19], 32'h100 + 19);

        // Reset mid-burst with a read in flight.
        cyc_start(); set_cpu(1, 0, 32'h10, 0);
        cyc_sample();
        cyc_start(); cyc_sample(); exp_read(PORT_CPU, 32'hDEADBEEF);
        cyc_start(); cyc_sample(); exp_read(PORT_CPU, 32'hDEADBEEF);
        @(posedge clock_i); #2;
        chk("t4_pre_rvalid", cpu_rvalid_o, 1);
        chk("t4_pre_gnt", cpu_gnt_o, 1);
        reset_i = 1'b1;
        cpu_q.delete();
        dbg_q.delete();
        #1;
        chk("t4_rst_cpu_gnt", cpu_gnt_o, 0);
        chk("t4_rst_cpu_rvalid", cpu_rvalid_o, 0);
        chk("t4_rst_cpu_rdata", cpu_rdata_o, 0);
        chk("t4_rst_ram_addr", ram_addr_o, 0);
        chk("t4_rst_ram_we", ram_we_o, 0);
        chk("t4_rst_state", dut.state_reg, IDLE);
        set_cpu(0, 0, 0, 0);
        repeat (2) @(posedge clock_i);
        #1 reset_i = 1'b0;
        repeat (5) begin
            cyc_start();
            cyc_sample();
        end
        chk("t4_idle_after", dut.state_reg, IDLE);

        // DBG alone: 300 consecutive write beats, counter saturates.
        for (int c = 0; c <= 302; c++) begin
            cyc_start();
            if (c <= 300) set_dbg(1, 1, 32'hC0 + (c % 16), c);
            else          set_dbg(0, 0, 0, 0);
            cyc_sample();
            if (c >= 1 && c <= 301) chk("t5_dbg_gnt_held", dbg_gnt_o, 1);
            if (c == 101) chk("t5_count_100", dut.count_reg, 100);
            if (c == 256) chk("t5_count_255", dut.count_reg, 255);
            if (c == 301) chk("t5_count_sat", dut.count_reg, 255);
        end
        chk("t5_back_idle", dut.state_reg, IDLE);
        chk("t5_last_write", mem[8'hC0 + (300 % 16)], 300);

        repeat (2) begin
            cyc_start();
            cyc_sample();
        end
        chk("end_cpu_q_empty", cpu_q.size(), 0);
        chk("end_dbg_q_empty", dbg_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
